ycr_pipe_mprf_np: RTL

//  Parametrised successor of the core's multi-port register file: NRD read ports, two write ports
//  (EXU writeback + late LSU/MUL writeback), optional registered read stage with write-first bypass.

---
 rtl/ycr_pipe_mprf_np.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/ycr_pipe_mprf_np.sv
// Multi-port register file: NRD read ports, two write ports, optional
// registered read with write-first bypass, sequential clear after reset.
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   clr_req_i         restart the clear sequence (ignored while clearing)
//   mprf_ready_o      1 when the array is valid (RUN)
//   rd_addr_i/rd_data_o  packed read ports, port k at [k*AW +: AW]
//   w0_*/w1_*         write ports; port 1 wins on same address
//   wr_collision_o    one-cycle pulse after both ports wrote one address
//   wr_drop_o         sticky: a write was dropped during clear
//   dbg_*_o           raw contents of x1/x2/x3/x10, zero while clearing
module ycr_pipe_mprf_np #(
   parameter int XLEN       = 32,
   parameter int DEPTH      = 32,
   parameter int NRD        = 2,
   parameter int READ_STAGE = 1
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            clr_req_i,
   output logic                            mprf_ready_o,
   input  logic [NRD*$clog2(DEPTH)-1:0]    rd_addr_i,
   output logic [NRD*XLEN-1:0]             rd_data_o,
   input  logic                            w0_req_i,
   input  logic [$clog2(DEPTH)-1:0]        w0_addr_i,
   input  logic [XLEN-1:0]                 w0_data_i,
   input  logic                            w1_req_i,
   input  logic [$clog2(DEPTH)-1:0]        w1_addr_i,
   input  logic [XLEN-1:0]                 w1_data_i,
   output logic                            wr_collision_o,
   output logic                            wr_drop_o,
   output logic [XLEN-1:0]                 dbg_ra_o,
   output logic [XLEN-1:0]                 dbg_sp_o,
   output logic [XLEN-1:0]                 dbg_gp_o,
   output logic [XLEN-1:0]                 dbg_a0_o
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } state_t;

   state_t          state;
   state_t          state_nx;
   logic [AW-1:0]   clr_idx;
   logic [AW-1:0]   clr_idx_nx;
   logic [XLEN-1:0] mem [DEPTH];
   logic            run;
   logic            w0_eff;
   logic            w1_eff;

   // Entry 0 and addresses past the end of a non-power-of-2 array are dead.
   function automatic logic in_rng(input logic [AW-1:0] a);
      return (a != '0) && (int'(a) < DEPTH);
   endfunction

   assign run          = (state == ST_RUN);
   assign mprf_ready_o = run;
   assign w0_eff       = run && w0_req_i && in_rng(w0_addr_i);
   assign w1_eff       = run && w1_req_i && in_rng(w1_addr_i);

   always_comb begin
      state_nx   = state;
      clr_idx_nx = clr_idx;
      unique case (state)
         ST_CLEAR: begin
            clr_idx_nx = clr_idx + AW'(1);
            if (clr_idx == AW'(DEPTH - 1)) state_nx = ST_RUN;
         end
         ST_RUN: begin
            if (clr_req_i) begin
               state_nx   = ST_CLEAR;
               clr_idx_nx = AW'(1);
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_CLEAR;
         clr_idx <= AW'(1);
      end else begin
         state   <= state_nx;
         clr_idx <= clr_idx_nx;
      end
   end

   // No reset on the array itself; the clear sequence zeroes it.
   always_ff @(posedge clk) begin
      if (!run) begin
         mem[clr_idx] <= '0;
      end else begin
         if (w0_eff) mem[w0_addr_i] <= w0_data_i;
         if (w1_eff) mem[w1_addr_i] <= w1_data_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_collision_o <= 1'b0;
         wr_drop_o      <= 1'b0;
      end else begin
         wr_collision_o <= w0_eff && w1_eff && (w0_addr_i == w1_addr_i);
         if (!run && (w0_req_i || w1_req_i)) wr_drop_o <= 1'b1;
         else if (run && clr_req_i)          wr_drop_o <= 1'b0;
      end
   end

   for (genvar k = 0; k < NRD; k++) begin : g_rd
      logic [AW-1:0]   ra;
      logic [XLEN-1:0] arr;
      assign ra  = rd_addr_i[k*AW +: AW];
      assign arr = (run && in_rng(ra)) ? mem[ra] : '0;
      if (READ_STAGE != 0) begin : g_reg
         logic [XLEN-1:0] q;
         // Write-first: a write landing on the sampled address this
         // cycle is forwarded, port 1 taking priority like the array.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)                             q <= '0;
            else if (w1_eff && (w1_addr_i == ra))   q <= w1_data_i;
            else if (w0_eff && (w0_addr_i == ra))   q <= w0_data_i;
            else                                    q <= arr;
         end
         assign rd_data_o[k*XLEN +: XLEN] = q;
      end else begin : g_comb
         assign rd_data_o[k*XLEN +: XLEN] = arr;
      end
   end

   assign dbg_ra_o = run ? mem[1] : '0;
   assign dbg_sp_o = run ? mem[2] : '0;
   assign dbg_gp_o = run ? mem[3] : '0;

   if (DEPTH > 10) begin : g_a0
      assign dbg_a0_o = run ? mem[10] : '0;
   end else begin : g_no_a0
      assign dbg_a0_o = '0;
   end

   a_w0_known : assert property (@(posedge clk) disable iff (!rst_n)
      (run && w0_req_i && (w0_addr_i != '0))
         |-> !$isunknown({w0_addr_i, w0_data_i}));

   a_w1_known : assert property (@(posedge clk) disable iff (!rst_n)
      (run && w1_req_i && (w1_addr_i != '0))
         |-> !$isunknown({w1_addr_i, w1_data_i}));

endmodule
